// File: rtl/adrf_bringup_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : adrf_bringup_ctrl_if
//  Brief    : Signal bundle between the bring-up sequencer and the ADRF
//             SPI configuration engine / modulator / TX datapath.
//  Revision : 1.0 - initial release
// ============================================================================
interface adrf_bringup_ctrl_if;
  logic adrf_ready;     // config-complete flag from the SPI config engine
  logic adrf_lock_det;  // raw LO lock-detect pin, asynchronous
  logic adrf_control;   // enable to the config engine
  logic adrf_reset;     // synchronous reset to the config engine
  logic tx_en;          // TX datapath enable

  // Sequencer side
  modport master (
    input  adrf_ready,
    input  adrf_lock_det,
    output adrf_control,
    output adrf_reset,
    output tx_en
  );

  // Engine / datapath side
  modport slave (
    output adrf_ready,
    output adrf_lock_det,
    input  adrf_control,
    input  adrf_reset,
    input  tx_en
  );
endinterface
`default_nettype wire

// File: rtl/adrf_bringup_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : adrf_bringup_ctrl
//  Brief    : Power-up and supervision sequencer for the ADRF SPI config
//             engine: power-up delay, config-ready wait, LO lock qualification,
//             TX enable, and bounded retries with a fault code.
//  Revision : 1.0 - initial release
// ============================================================================
module adrf_bringup_ctrl #(
  parameter int PWRUP_CYCLES  = 1000,
  parameter int READY_TIMEOUT = 4096,
  parameter int LOCK_STABLE   = 256,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int MAX_RETRY     = 3
) (
  input  wire logic             GCLK,
  input  wire logic             reset,
  input  wire logic             start,
  input  wire logic             stop,
  adrf_bringup_ctrl_if.master   adrf,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [1:0]            err_code,
  output logic [1:0]            retry_cnt
);

  localparam logic [2:0] c_st_idle      = 3'd0;
  localparam logic [2:0] c_st_pwrup     = 3'd1;
  localparam logic [2:0] c_st_config    = 3'd2;
  localparam logic [2:0] c_st_lock_wait = 3'd3;
  localparam logic [2:0] c_st_run       = 3'd4;
  localparam logic [2:0] c_st_retry     = 3'd5;
  localparam logic [2:0] c_st_fail      = 3'd6;

  localparam logic [16:0] c_pwrup_last  = 17'(PWRUP_CYCLES - 1);
  localparam logic [16:0] c_ready_last  = 17'(READY_TIMEOUT - 1);
  localparam logic [16:0] c_lock_last   = 17'(LOCK_TIMEOUT - 1);
  localparam logic [16:0] c_retry_last  = 17'd15;  // 16-cycle engine reset hold
  localparam logic [8:0]  c_stable_last = 9'(LOCK_STABLE - 1);
  localparam logic [1:0]  c_max_retry   = 2'(MAX_RETRY);

  localparam logic [1:0] c_err_none       = 2'b00;
  localparam logic [1:0] c_err_ready_to   = 2'b01;
  localparam logic [1:0] c_err_lock_to    = 2'b10;
  localparam logic [1:0] c_err_lock_lost  = 2'b11;

  logic [2:0]  r_state;
  logic [2:0]  w_state_nxt;
  logic [16:0] r_timer;
  logic [8:0]  r_stable;
  logic        r_lock_meta;
  logic        r_lock_s;
  logic [1:0]  r_err_code;
  logic [1:0]  r_retry_cnt;
  logic        r_adrf_control;
  logic        r_adrf_reset;
  logic        r_tx_en;
  logic        r_busy;
  logic        r_done;
  logic        r_error;

  logic        w_clr_status;
  logic        w_err_load;
  logic [1:0]  w_err_val;
  logic        w_retry_inc;

  // Two-flop synchronizer for the asynchronous lock-detect pin
  always_ff @(posedge GCLK) begin
    if (reset) begin
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
    end else begin
      r_lock_meta <= adrf.adrf_lock_det;
      r_lock_s    <= r_lock_meta;
    end
  end

  // Next-state and status-update decode; stop overrides everything
  always_comb begin
    w_state_nxt  = r_state;
    w_clr_status = 1'b0;
    w_err_load   = 1'b0;
    w_err_val    = c_err_none;
    w_retry_inc  = 1'b0;
    case (r_state)
      c_st_idle, c_st_fail: begin
        if (start) begin
          w_state_nxt  = c_st_pwrup;
          w_clr_status = 1'b1;
        end
      end
      c_st_pwrup: begin
        if (r_timer == c_pwrup_last) w_state_nxt = c_st_config;
      end
      c_st_config: begin
        if (adrf.adrf_ready) begin
          w_state_nxt = c_st_lock_wait;
        end else if (r_timer == c_ready_last) begin
          w_state_nxt = c_st_retry;
          w_err_load  = 1'b1;
          w_err_val   = c_err_ready_to;
        end
      end
      c_st_lock_wait: begin
        if (r_lock_s && (r_stable == c_stable_last)) begin
          w_state_nxt = c_st_run;
        end else if (r_timer == c_lock_last) begin
          w_state_nxt = c_st_retry;
          w_err_load  = 1'b1;
          w_err_val   = c_err_lock_to;
        end
      end
      c_st_run: begin
        if (!r_lock_s) begin
          w_state_nxt = c_st_retry;
          w_err_load  = 1'b1;
          w_err_val   = c_err_lock_lost;
        end
      end
      c_st_retry: begin
        // retry_cnt cannot change while in RETRY, so this is the entry value
        if (r_retry_cnt == c_max_retry) begin
          w_state_nxt = c_st_fail;
        end else if (r_timer == c_retry_last) begin
          w_state_nxt = c_st_config;
          w_retry_inc = 1'b1;
        end
      end
      default: w_state_nxt = c_st_idle;
    endcase
    if (stop) begin
      w_state_nxt  = c_st_idle;
      w_clr_status = 1'b0;
      w_err_load   = 1'b0;
      w_retry_inc  = 1'b0;
    end
  end

  // State, shared timer (cleared on every state change, saturating) and lock-stable counter
  always_ff @(posedge GCLK) begin
    if (reset) begin
      r_state  <= c_st_idle;
      r_timer  <= '0;
      r_stable <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt != r_state) r_timer <= '0;
      else if (r_timer != '1)     r_timer <= r_timer + 17'd1;
      if ((r_state != c_st_lock_wait) || !r_lock_s) r_stable <= '0;
      else if (r_stable != '1)                       r_stable <= r_stable + 9'd1;
    end
  end

  // Fault code and retry counter; both survive stop and clear only on start
  always_ff @(posedge GCLK) begin
    if (reset) begin
      r_err_code  <= c_err_none;
      r_retry_cnt <= '0;
    end else if (w_clr_status) begin
      r_err_code  <= c_err_none;
      r_retry_cnt <= '0;
    end else begin
      if (w_err_load)  r_err_code  <= w_err_val;
      if (w_retry_inc) r_retry_cnt <= r_retry_cnt + 2'd1;
    end
  end

  // Registered outputs decoded from the next state so they line up with r_state
  always_ff @(posedge GCLK) begin
    if (reset) begin
      r_adrf_control <= 1'b0;
      r_adrf_reset   <= 1'b1;
      r_tx_en        <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_error        <= 1'b0;
    end else begin
      r_adrf_control <= (w_state_nxt == c_st_config) || (w_state_nxt == c_st_lock_wait) ||
                        (w_state_nxt == c_st_run);
      r_adrf_reset   <= (w_state_nxt == c_st_idle) || (w_state_nxt == c_st_pwrup) ||
                        (w_state_nxt == c_st_retry) || (w_state_nxt == c_st_fail);
      r_tx_en        <= (w_state_nxt == c_st_run);
      r_busy         <= (w_state_nxt == c_st_pwrup) || (w_state_nxt == c_st_config) ||
                        (w_state_nxt == c_st_lock_wait) || (w_state_nxt == c_st_retry);
      r_done         <= (w_state_nxt == c_st_run);
      r_error        <= (w_state_nxt == c_st_fail);
    end
  end

  assign adrf.adrf_control = r_adrf_control;
  assign adrf.adrf_reset   = r_adrf_reset;
  assign adrf.tx_en        = r_tx_en;
  assign busy              = r_busy;
  assign done              = r_done;
  assign error             = r_error;
  assign err_code          = r_err_code;
  assign retry_cnt         = r_retry_cnt;

endmodule
`default_nettype wire

// File: tb/tb_adrf_bringup_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_adrf_bringup_ctrl
//  Brief    : Directed self-checking bench for adrf_bringup_ctrl with short
//             timing parameters; expected values are hand-computed cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_adrf_bringup_ctrl;

  logic       GCLK = 1'b0;
  logic       reset;
  logic       start;
  logic       stop;
  logic       busy;
  logic       done;
  logic       error;
  logic [1:0] err_code;
  logic [1:0] retry_cnt;
  int         cyc = 0;
  int         n_vec = 0;
  int         n_err = 0;

  adrf_bringup_ctrl_if adrf_bus ();

  adrf_bringup_ctrl #(
    .PWRUP_CYCLES  (8),
    .READY_TIMEOUT (64),
    .LOCK_STABLE   (4),
    .LOCK_TIMEOUT  (128),
    .MAX_RETRY     (2)
  ) dut (
    .GCLK      (GCLK),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .adrf      (adrf_bus.master),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .err_code  (err_code),
    .retry_cnt (retry_cnt)
  );

  // 10 ns clock
  always #5 GCLK = ~GCLK;

  // Cycle index: value k means "just after the k-th rising edge"
  always @(posedge GCLK) cyc <= cyc + 1;

  // Hard stop in case the sequence never completes
  initial begin
    #200000;
    $display("FAIL watchdog: sequence did not complete at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge GCLK);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Directed sequence
  initial begin
    int   s;
    int   ph;
    logic saw_run;

    reset = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    adrf_bus.adrf_ready    = 1'b0;
    adrf_bus.adrf_lock_det = 1'b1;

    // ---- reset state
    wait_until(3);
    chk1("rst_adrf_reset", adrf_bus.adrf_reset, 1'b1);
    chk1("rst_adrf_control", adrf_bus.adrf_control, 1'b0);
    chk1("rst_tx_en", adrf_bus.tx_en, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_error", error, 1'b0);
    chk2("rst_err_code", err_code, 2'b00);
    chk2("rst_retry_cnt", retry_cnt, 2'd0);
    reset = 1'b0;

    // ---- nominal bring-up: start at 10, ready at 40, lock high throughout
    wait_until(10);
    start = 1'b1;
    tick();                                   // 11: PWRUP
    start = 1'b0;
    chk1("nom_pwrup_busy", busy, 1'b1);
    chk1("nom_pwrup_reset", adrf_bus.adrf_reset, 1'b1);
    wait_until(18);
    chk1("nom_last_pwrup_ctrl", adrf_bus.adrf_control, 1'b0);
    tick();                                   // 19: first CONFIG
    chk1("nom_cfg_ctrl", adrf_bus.adrf_control, 1'b1);
    chk1("nom_cfg_reset", adrf_bus.adrf_reset, 1'b0);
    wait_until(40);
    adrf_bus.adrf_ready = 1'b1;
    wait_until(44);
    chk1("nom_lockwait_done", done, 1'b0);
    tick();                                   // 45: RUN
    chk1("nom_run_done", done, 1'b1);
    chk1("nom_run_tx_en", adrf_bus.tx_en, 1'b1);
    chk1("nom_run_busy", busy, 1'b0);
    chk2("nom_run_err_code", err_code, 2'b00);

    // ---- lock loss in RUN: raw lock low for one cycle at 50
    wait_until(50);
    adrf_bus.adrf_lock_det = 1'b0;
    tick();                                   // 51
    adrf_bus.adrf_lock_det = 1'b1;
    tick();                                   // 52: lock_s low, still RUN
    chk1("loss_t2_tx_en", adrf_bus.tx_en, 1'b1);
    tick();                                   // 53: RETRY
    adrf_bus.adrf_ready = 1'b0;
    chk1("loss_t3_tx_en", adrf_bus.tx_en, 1'b0);
    chk2("loss_err_code", err_code, 2'b11);
    chk1("loss_retry_reset", adrf_bus.adrf_reset, 1'b1);
    wait_until(68);                           // last of 16 RETRY cycles
    chk1("loss_retry16_reset", adrf_bus.adrf_reset, 1'b1);
    chk2("loss_retry16_cnt", retry_cnt, 2'd0);
    tick();                                   // 69: CONFIG
    chk1("loss_cfg_reset", adrf_bus.adrf_reset, 1'b0);
    chk2("loss_cfg_cnt", retry_cnt, 2'd1);
    adrf_bus.adrf_ready = 1'b1;
    wait_until(73);
    chk1("loss_relock_wait", done, 1'b0);
    tick();                                   // 74: RUN again
    chk1("loss_rerun_done", done, 1'b1);
    chk2("loss_rerun_err_code", err_code, 2'b11);
    chk2("loss_rerun_cnt", retry_cnt, 2'd1);

    // ---- reset in RUN
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk1("rrun_adrf_reset", adrf_bus.adrf_reset, 1'b1);
    chk1("rrun_adrf_control", adrf_bus.adrf_control, 1'b0);
    chk1("rrun_tx_en", adrf_bus.tx_en, 1'b0);
    chk1("rrun_done", done, 1'b0);
    chk2("rrun_err_code", err_code, 2'b00);
    chk2("rrun_retry_cnt", retry_cnt, 2'd0);

    // ---- lock chatter: 3 high / 3 low, ready already high
    s = cyc;
    start = 1'b1;
    tick();                                   // s+1: PWRUP
    start = 1'b0;
    ph = 0;
    saw_run = 1'b0;
    while (cyc < s + 137) begin               // LOCK_WAIT spans s+10 .. s+137
      adrf_bus.adrf_lock_det = ((ph / 3) % 2) == 0;
      ph++;
      tick();
      if (done) saw_run = 1'b1;
    end
    chk1("chat_never_run", saw_run, 1'b0);
    chk1("chat_last_wait_ctrl", adrf_bus.adrf_control, 1'b1);
    chk2("chat_last_wait_err", err_code, 2'b00);
    tick();                                   // s+138: RETRY
    chk2("chat_err_code", err_code, 2'b10);
    chk1("chat_retry_reset", adrf_bus.adrf_reset, 1'b1);
    adrf_bus.adrf_lock_det = 1'b1;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk1("chat_stop_busy", busy, 1'b0);
    chk2("chat_stop_err_kept", err_code, 2'b10);

    // ---- ready timeout x3 -> FAIL
    adrf_bus.adrf_ready = 1'b0;
    s = cyc;
    start = 1'b1;
    tick();                                   // s+1: PWRUP
    start = 1'b0;
    chk2("to_start_err_clr", err_code, 2'b00);
    wait_until(s + 72);                       // 64th CONFIG cycle
    chk1("to_cfg64_ctrl", adrf_bus.adrf_control, 1'b1);
    tick();                                   // s+73: RETRY
    chk2("to1_err_code", err_code, 2'b01);
    chk1("to1_reset", adrf_bus.adrf_reset, 1'b1);
    chk2("to1_cnt", retry_cnt, 2'd0);
    wait_until(s + 88);
    chk1("to1_retry16_reset", adrf_bus.adrf_reset, 1'b1);
    tick();                                   // s+89: CONFIG
    chk2("to1_cfg_cnt", retry_cnt, 2'd1);
    chk1("to1_cfg_reset", adrf_bus.adrf_reset, 1'b0);
    wait_until(s + 168);
    chk1("to2_retry_reset", adrf_bus.adrf_reset, 1'b1);
    tick();                                   // s+169: CONFIG
    chk2("to2_cfg_cnt", retry_cnt, 2'd2);
    wait_until(s + 233);                      // single RETRY cycle
    chk1("to3_retry_busy", busy, 1'b1);
    chk1("to3_retry_error", error, 1'b0);
    tick();                                   // s+234: FAIL
    chk1("fail_error", error, 1'b1);
    chk1("fail_busy", busy, 1'b0);
    chk2("fail_cnt", retry_cnt, 2'd2);
    chk2("fail_err_code", err_code, 2'b01);
    chk1("fail_reset", adrf_bus.adrf_reset, 1'b1);
    tick();
    chk1("fail_hold_error", error, 1'b1);

    // ---- FAIL recovery, then stop mid-CONFIG
    start = 1'b1;
    tick();                                   // PWRUP
    start = 1'b0;
    s = cyc;
    chk1("rec_error", error, 1'b0);
    chk2("rec_cnt", retry_cnt, 2'd0);
    chk2("rec_err_code", err_code, 2'b00);
    chk1("rec_busy", busy, 1'b1);
    wait_until(s + 8);
    chk1("rec_cfg_ctrl", adrf_bus.adrf_control, 1'b1);
    wait_until(s + 20);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk1("stop_cfg_ctrl", adrf_bus.adrf_control, 1'b0);
    chk1("stop_cfg_reset", adrf_bus.adrf_reset, 1'b1);
    chk1("stop_cfg_busy", busy, 1'b0);

    // ---- stop and start together in IDLE: stop wins
    stop  = 1'b1;
    start = 1'b1;
    tick();
    stop  = 1'b0;
    start = 1'b0;
    chk1("stopstart_busy", busy, 1'b0);
    tick();
    chk1("stopstart_busy_hold", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
